lcd_vblank_scheduler: RTL



---
 rtl/lcd_sched_pkg.sv | 22 ++
 rtl/lcd_rr_pick.sv | 40 ++++
 rtl/lcd_vblank_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/lcd_sched_pkg.sv
// ============================================================
// lcd_sched_pkg: shared state encoding and defaults for the vblank scheduler
// Rev 1.0
// ============================================================
`default_nettype none

package lcd_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARB   = 2'd1,
    ST_GRANT = 2'd2
  } sched_state_e;

  localparam int DEF_N_REQ        = 4;
  localparam int DEF_SLOT_TIMEOUT = 4096;
  localparam int DEF_FCNT_W       = 16;
  localparam int COORD_W          = 11;

endpackage

`default_nettype wire

// File: rtl/lcd_rr_pick.sv
// ============================================================
// lcd_rr_pick: first pending bit at or after ptr_i, wrapping
// Rev 1.0
// ============================================================
`default_nettype none

module lcd_rr_pick
  import lcd_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] onehot_o,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] pos;

  // Scan from the farthest candidate back to ptr_i so the nearest pending bit wins.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      pos = IDX_W'((int'(ptr_i) + k) % N_REQ);
      if (pending_i[pos]) begin
        valid_o = 1'b1;
        idx_o   = pos;
      end
    end
  end

  assign onehot_o = valid_o ? (N_REQ'(1) << idx_o) : '0;

endmodule

`default_nettype wire

// File: rtl/lcd_vblank_scheduler.sv
// ============================================================
// lcd_vblank_scheduler: frame tick and round-robin update slots in vblank
// Rev 1.0
// ============================================================
`default_nettype none

module lcd_vblank_scheduler
  import lcd_sched_pkg::*;
#(
  parameter int N_REQ        = DEF_N_REQ,
  parameter int SLOT_TIMEOUT = DEF_SLOT_TIMEOUT,
  parameter int FCNT_W       = DEF_FCNT_W
) (
  input  logic               lcd_pclk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] pixel_xpos,
  input  logic [COORD_W-1:0] pixel_ypos,
  input  logic [COORD_W-1:0] h_disp,
  input  logic [COORD_W-1:0] v_disp,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   gnt,
  output logic               vblank,
  output logic               frame_tick,
  output logic [N_REQ-1:0]   overrun,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (SLOT_TIMEOUT > 2) ? $clog2(SLOT_TIMEOUT) : 1;

  sched_state_e      state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]  gidx_q, gidx_d;
  logic [N_REQ-1:0]  served_q, served_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q, tick_d;
  logic [N_REQ-1:0]  ovr_q, ovr_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  logic              fe, fs, done_g, timeout;
  logic [IDX_W-1:0]  next_g;
  logic [N_REQ-1:0]  pick_onehot;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;

  assign fe      = (pixel_xpos == h_disp) && (pixel_ypos == v_disp) && (pixel_xpos != '0);
  assign fs      = (pixel_xpos == COORD_W'(1)) && (pixel_ypos == COORD_W'(1));
  assign done_g  = done[gidx_q];
  assign timeout = (cnt_q == CNT_W'(SLOT_TIMEOUT - 1));
  assign next_g  = (gidx_q == IDX_W'(N_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);

  lcd_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .pending_i (req & ~served_q),
    .ptr_i     (rr_q),
    .onehot_o  (pick_onehot),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gidx_d   = gidx_q;
    served_d = served_q;
    rr_d     = rr_q;
    cnt_d    = cnt_q;
    tick_d   = 1'b0;
    ovr_d    = '0;
    fcnt_d   = fcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (fe) begin
          state_d  = ST_ARB;
          tick_d   = 1'b1;
          fcnt_d   = fcnt_q + FCNT_W'(1);
          served_d = '0;
        end
      end
      ST_ARB: begin
        if (fe) begin
          tick_d   = 1'b1;
          fcnt_d   = fcnt_q + FCNT_W'(1);
          served_d = '0;
        end else if (fs) begin
          state_d  = ST_IDLE;
          served_d = '0;
        end else if (pick_valid) begin
          state_d = ST_GRANT;
          gnt_d   = pick_onehot;
          gidx_d  = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        // Any exit revokes the slot; a coincident done always counts as a clean release.
        if (fe || fs || done_g || timeout) begin
          gnt_d = '0;
          rr_d  = next_g;
          if (!done_g) ovr_d = gnt_q;
          if (fe) begin
            state_d  = ST_ARB;
            tick_d   = 1'b1;
            fcnt_d   = fcnt_q + FCNT_W'(1);
            served_d = '0;
          end else if (fs) begin
            state_d  = ST_IDLE;
            served_d = '0;
          end else begin
            state_d  = ST_ARB;
            served_d = served_q | gnt_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gidx_q   <= '0;
      served_q <= '0;
      rr_q     <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      ovr_q    <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gidx_q   <= gidx_d;
      served_q <= served_d;
      rr_q     <= rr_d;
      cnt_q    <= cnt_d;
      tick_q   <= tick_d;
      ovr_q    <= ovr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  assign gnt        = gnt_q;
  assign vblank     = (state_q != ST_IDLE);
  assign frame_tick = tick_q;
  assign overrun    = ovr_q;
  assign frame_cnt  = fcnt_q;

endmodule

`default_nettype wire
